mem_resp_slave: RTL and testbench



---
 rtl/mem_resp_slave_pkg.sv | 19 +
 rtl/mem_word_array.sv | 66 ++++++
 rtl/mem_resp_slave.sv | 144 ++++++++++++++
 tb/tb_mem_resp_slave.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_slave_pkg.sv
// ----------------------------------------------------------------------------
// mem_resp_slave_pkg
// Shared definitions for the data-memory responder:
//   state_e  - FSM state encoding (IDLE / BUSY / RESP)
//   STRB_W   - number of byte lanes in a 32-bit word
//   CNT_W    - width of the latency down-counter (LATENCY up to 15)
// ----------------------------------------------------------------------------
package mem_resp_slave_pkg;

    localparam int STRB_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage : mem_resp_slave_pkg

// File: rtl/mem_word_array.sv
// ----------------------------------------------------------------------------
// mem_word_array
// Synchronous single-port 32-bit word RAM with per-byte write enables and a
// registered read port. The read register only updates when re is high, so
// rdata holds the last word read until the next read.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (read register only)
//   we     in   write enable
//   re     in   read enable
//   addr   in   word index
//   wdata  in   write data, lane aligned
//   wstrb  in   byte enables, bit i covers wdata[8i+7:8i]
//   rdata  out  registered read word
// ----------------------------------------------------------------------------
module mem_word_array
    import mem_resp_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [STRB_W-1:0]     wstrb,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // NOTE: the storage array has no reset branch; resetting it would turn
    // the RAM into thousands of individually reset flops.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule : mem_word_array

// File: rtl/mem_resp_slave.sv
// ----------------------------------------------------------------------------
// mem_resp_slave
// Data-memory responder for the CPU load/store port. Accepts one word-aligned
// read or write at a time, spends LATENCY cycles in BUSY, then commits the
// byte-masked write (back to IDLE) or presents the read word on a
// valid/ready handshake (RESP until the CPU takes it).
// Ports:
//   clk              in   clock, rising edge
//   rst              in   synchronous active-high reset
//   Address          in   byte address; [DEPTH_LOG2+1:2] selects the word
//   MemWrite         in   write request (wins when MemRead is also high)
//   MemRead          in   read request
//   Write_data       in   lane-aligned write data
//   Write_strb       in   byte enables
//   Mem_Req_Ready    out  request accepted when high with MemRead|MemWrite
//   Read_data        out  full read word, held after the handshake
//   Read_data_Valid  out  Read_data valid
//   Read_data_Ready  in   CPU accepts read data
// ----------------------------------------------------------------------------
module mem_resp_slave
    import mem_resp_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Address,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [31:0]       Write_data,
    input  logic [STRB_W-1:0] Write_strb,
    output logic              Mem_Req_Ready,
    output logic [31:0]       Read_data,
    output logic              Read_data_Valid,
    input  logic              Read_data_Ready
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [STRB_W-1:0]       strb_q, strb_d;
    logic                    is_write_q, is_write_d;
    logic                    valid_q, valid_d;
    logic                    ram_we, ram_re;

    // Byte offset and bits above the array size do not select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Address[31:DEPTH_LOG2+2], Address[1:0]};

    assign Mem_Req_Ready   = (state_q == S_IDLE) && !rst;
    assign Read_data_Valid = valid_q;

    // NOTE: every signal gets a default before the case statement so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        is_write_d = is_write_q;
        valid_d    = valid_q;
        ram_we     = 1'b0;
        ram_re     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    idx_d      = Address[DEPTH_LOG2+1:2];
                    wdata_d    = Write_data;
                    strb_d     = Write_strb;
                    is_write_d = MemWrite;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q == '0) begin
                    if (is_write_q) begin
                        ram_we  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ram_re  = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                // Returning to IDLE here means a request waiting during the
                // handshake is taken no earlier than the following edge.
                if (Read_data_Ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            is_write_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            is_write_q <= is_write_d;
            valid_q    <= valid_d;
        end
    end

    // Gating with rst drops a commit that would coincide with reset, so a
    // reset mid-operation never touches memory.
    mem_word_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we && !rst),
        .re    (ram_re && !rst),
        .addr  (idx_q),
        .wdata (wdata_q),
        .wstrb (strb_q),
        .rdata (Read_data)
    );

endmodule : mem_resp_slave

// File: tb/tb_mem_resp_slave.sv
// ----------------------------------------------------------------------------
// tb_mem_resp_slave
// Self-checking bench for mem_resp_slave. Expected read words are pushed to a
// scoreboard queue when a read request is driven and popped when the DUT
// raises Read_data_Valid. Inputs change and outputs are sampled on the
// falling clock edge.
// ----------------------------------------------------------------------------
module tb_mem_resp_slave;

    localparam int DEPTH_LOG2 = 8;
    localparam int LATENCY    = 2;
    localparam int TIMEOUT    = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Address;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    mem_resp_slave #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .LATENCY    (LATENCY)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Address         (Address),
        .MemWrite        (MemWrite),
        .MemRead         (MemRead),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .Mem_Req_Ready   (Mem_Req_Ready),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ready (Read_data_Ready)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drive a request and hold it until accepted; returns at the falling
    // edge one cycle after the accepting edge, with the request dropped.
    task automatic issue(input logic [31:0] addr, input logic wr, input logic rd,
                         input logic [31:0] data, input logic [3:0] strb);
        int w;
        @(negedge clk);
        Address    = addr;
        MemWrite   = wr;
        MemRead    = rd;
        Write_data = data;
        Write_strb = strb;
        w = 0;
        while (!Mem_Req_Ready && w < TIMEOUT) begin
            @(negedge clk);
            w++;
        end
        nvec++;
        if (Mem_Req_Ready !== 1'b1) begin
            $display("FAIL issue_accept: Mem_Req_Ready=%b required 1", Mem_Req_Ready);
            nerr++;
        end
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!Mem_Req_Ready && w < TIMEOUT) begin
            @(negedge clk);
            w++;
        end
        nvec++;
        if (Mem_Req_Ready !== 1'b1) begin
            $display("FAIL ready_return: Mem_Req_Ready=%b required 1", Mem_Req_Ready);
            nerr++;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
        issue(addr, 1'b1, 1'b0, data, strb);
        wait_ready();
    endtask

    // Read with Read_data_Ready high; checks data from the scoreboard,
    // optionally the valid latency, and the post-handshake state.
    task automatic do_read(input string name, input logic [31:0] addr,
                           input logic [31:0] expv, input bit check_lat);
        int          lat;
        logic [31:0] want;
        exp_q.push_back(expv);
        Read_data_Ready = 1'b1;
        issue(addr, 1'b0, 1'b1, 32'h0, 4'h0);
        lat = 1;
        while (!Read_data_Valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        want = exp_q.pop_front();
        nvec++;
        if (Read_data_Valid !== 1'b1) begin
            $display("FAIL %s_valid_timeout: Read_data_Valid=%b required 1", name, Read_data_Valid);
            nerr++;
        end else if (Read_data !== want) begin
            $display("FAIL %s_data: got %h required %h", name, Read_data, want);
            nerr++;
        end
        if (check_lat) begin
            nvec++;
            if (lat != LATENCY + 1) begin
                $display("FAIL %s_latency: got %0d required %0d", name, lat, LATENCY + 1);
                nerr++;
            end
        end
        @(negedge clk);
        nvec++;
        if (Read_data_Valid !== 1'b0 || Mem_Req_Ready !== 1'b1) begin
            $display("FAIL %s_handshake: valid=%b ready=%b required valid=0 ready=1",
                     name, Read_data_Valid, Mem_Req_Ready);
            nerr++;
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        Address         = '0;
        MemWrite        = 1'b0;
        MemRead         = 1'b0;
        Write_data      = '0;
        Write_strb      = '0;
        Read_data_Ready = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if (Mem_Req_Ready !== 1'b0 || Read_data_Valid !== 1'b0 || Read_data !== 32'h0) begin
            $display("FAIL reset_state: ready=%b valid=%b data=%h required 0 0 00000000",
                     Mem_Req_Ready, Read_data_Valid, Read_data);
            nerr++;
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (Mem_Req_Ready !== 1'b1) begin
            $display("FAIL reset_release_ready: got %b required 1", Mem_Req_Ready);
            nerr++;
        end
    endtask

    task automatic test_full_write_read();
        issue(32'h10, 1'b1, 1'b0, 32'hDEADBEEF, 4'hF);
        // Falling edges 1..LATENCY after acceptance are still busy.
        for (int i = 1; i <= LATENCY; i++) begin
            nvec++;
            if (Mem_Req_Ready !== 1'b0) begin
                $display("FAIL write_busy_%0d: Mem_Req_Ready=%b required 0", i, Mem_Req_Ready);
                nerr++;
            end
            @(negedge clk);
        end
        nvec++;
        if (Mem_Req_Ready !== 1'b1) begin
            $display("FAIL write_spacing: Mem_Req_Ready=%b required 1", Mem_Req_Ready);
            nerr++;
        end
        do_read("full_rw", 32'h10, 32'hDEADBEEF, 1'b1);
    endtask

    task automatic test_byte_merge();
        do_write(32'h20, 32'h11223344, 4'b1111);
        do_write(32'h22, 32'h00AA0000, 4'b0100);
        do_read("merge", 32'h20, 32'h11AA3344, 1'b1);
        do_write(32'h20, 32'hFFFFFFFF, 4'b0000);
        do_read("strb_zero", 32'h20, 32'h11AA3344, 1'b0);
    endtask

    task automatic test_backpressure();
        int          w;
        logic [31:0] want;
        do_write(32'h50, 32'hCAFEF00D, 4'hF);
        Read_data_Ready = 1'b0;
        exp_q.push_back(32'hCAFEF00D);
        issue(32'h50, 1'b0, 1'b1, 32'h0, 4'h0);
        w = 0;
        while (!Read_data_Valid && w < TIMEOUT) begin
            @(negedge clk);
            w++;
        end
        want = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if (Read_data_Valid !== 1'b1 || Read_data !== want) begin
                $display("FAIL bp_hold_%0d: valid=%b data=%h required 1 %h",
                         i, Read_data_Valid, Read_data, want);
                nerr++;
            end
            @(negedge clk);
        end
        Read_data_Ready = 1'b1;
        @(negedge clk);
        nvec++;
        if (Read_data_Valid !== 1'b0 || Mem_Req_Ready !== 1'b1 || Read_data !== want) begin
            $display("FAIL bp_release: valid=%b ready=%b data=%h required 0 1 %h",
                     Read_data_Valid, Mem_Req_Ready, Read_data, want);
            nerr++;
        end
    endtask

    task automatic test_simultaneous();
        logic saw_valid;
        do_write(32'h40, 32'h0, 4'hF);
        issue(32'h40, 1'b1, 1'b1, 32'h0000BEEF, 4'b0011);
        saw_valid = 1'b0;
        for (int i = 0; i < 3 * LATENCY + 4; i++) begin
            saw_valid |= Read_data_Valid;
            @(negedge clk);
        end
        nvec++;
        if (saw_valid !== 1'b0) begin
            $display("FAIL rw_no_valid: saw Read_data_Valid=%b required 0", saw_valid);
            nerr++;
        end
        wait_ready();
        do_read("rw_result", 32'h40, 32'h0000BEEF, 1'b0);
    endtask

    task automatic test_reset_busy();
        do_write(32'h30, 32'h0, 4'hF);
        issue(32'h30, 1'b1, 1'b0, 32'hFFFFFFFF, 4'hF);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nvec++;
            if (Mem_Req_Ready !== 1'b0) begin
                $display("FAIL rst_busy_ready_%0d: got %b required 0", i, Mem_Req_Ready);
                nerr++;
            end
        end
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if (Mem_Req_Ready !== 1'b1 || Read_data_Valid !== 1'b0) begin
            $display("FAIL rst_busy_release: ready=%b valid=%b required 1 0",
                     Mem_Req_Ready, Read_data_Valid);
            nerr++;
        end
        do_read("rst_busy_mem", 32'h30, 32'h0, 1'b0);
    endtask

    task automatic test_aliasing();
        do_write(32'h0000_0404, 32'h12345678, 4'hF);
        do_read("alias_04", 32'h0000_0004, 32'h12345678, 1'b0);
        do_read("alias_07", 32'h0000_0007, 32'h12345678, 1'b1);
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_byte_merge();
        test_backpressure();
        test_simultaneous();
        test_reset_busy();
        test_aliasing();
        nvec++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
            nerr++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_mem_resp_slave
